adc_sampler: RTL and testbench
==============================

// Module: adc_sampler
// PURPOSE
//  Downstream consumer and scheduler for the dual-channel ADC SPI block. Issues one
//  conversion trigger every PERIOD clocks, waits for the conversion handshake, captures
//  both 14-bit two's-complement channels and box-car averages 2**AVG_LOG2 conversions.
//  Presents averaged A/B samples on a valid/ready port with overrun and timeout flags.
// PARAMETERS
//  PERIOD    1000  clocks between trigger ticks (50 kHz at 50 MHz); legal range >= 8
//  AVG_LOG2  2     log2 of conversions per output sample; legal range 0..8
//  TIMEOUT   255   max clocks spent in WAIT_BUSY or WAIT_DONE before abort
// PORTS
//  CLK50MHZ     in   1   system clock; all logic on rising edge
//  RST          in   1   asynchronous, active-low reset
//  en           in   1   enable sampling
//  adc_trig     out  1   one-cycle conversion start pulse to ADC block
//  adc_done     in   1   ADC ready level: high idle, low while converting
//  adc_a        in   14  channel A result, valid while adc_done high after conversion
//  adc_b        in   14  channel B result, valid while adc_done high after conversion
//  smp_a        out  14  averaged channel A, signed
//  smp_b        out  14  averaged channel B, signed
//  smp_valid    out  1   smp_a/smp_b hold a sample not yet accepted
//  smp_ready    in   1   consumer accepts; transfer when smp_valid & smp_ready
//  overrun      out  1   sticky: an average was discarded
//  timeout_err  out  1   sticky: conversion handshake timed out
//  clr_err      in   1   clears overrun and timeout_err
// BEHAVIOUR
//  Reset: state IDLE; period, timeout and sample counters 0; accumulators 0;
//   pending 0; all outputs 0.
//  Period counter: runs 0..PERIOD-1 while en=1, held at 0 while en=0. A tick at
//   count PERIOD-1 sets pending. Ticks arriving while pending=1 are dropped. No queueing.
//  FSM:
//   IDLE: en & pending -> TRIG; clear pending. With en=0, accumulators and n are cleared.
//   TRIG: adc_trig=1 for exactly this cycle; timeout counter cleared -> WAIT_BUSY.
//   WAIT_BUSY: adc_done=0 -> WAIT_DONE.
//   WAIT_DONE: adc_done=1 -> register adc_a/adc_b into capture regs -> ACC.
//   ACC: sign-extend captures into accumulators of width 14+AVG_LOG2, then n++.
//    If n was 2**AVG_LOG2-1:
//     - output = accumulator >>> AVG_LOG2 (arithmetic, floor), low 14 bits;
//     - accumulators and n cleared.
//    Always -> IDLE.
//   Timeout: in WAIT_BUSY or WAIT_DONE, the timeout counter increments each cycle.
//    Reaching TIMEOUT sets timeout_err and -> IDLE, discarding that conversion;
//    accumulators are kept.
//  Latency: tick seen in IDLE -> adc_trig high 2 cycles after the tick cycle.
//   adc_done rise seen in WAIT_DONE at cycle D -> smp_valid high at D+2.
//  en falling mid-conversion: in-flight conversion completes normally; no new trigger.
//  Output load, on completion of an average:
//   - smp_valid=0, or smp_valid&smp_ready in the same cycle: load smp_a/smp_b, smp_valid=1.
//   - otherwise: keep the held sample, discard the new one, set overrun.
//   smp_valid clears on smp_ready when no load occurs.
//  clr_err clears both flags; a set in the same cycle as clr_err wins.
//  Async RST mid-operation: immediate return to reset values; adc_trig drops at once.
// TESTING
//  1 AVG_LOG2=0, PERIOD=100, model returns a=14'h1FFF b=14'h2000, smp_ready=1
//    -> adc_trig every 100 clk; smp_a=14'h1FFF, smp_b=14'h2000 per trigger.
//  2 AVG_LOG2=2, a sequence +4,+4,-4,-8 -> one smp_valid, smp_a=14'h3FFF (-1, floor);
//    a constant 14'h0005 x4 -> smp_a=14'h0005.
//  3 smp_ready=0 across two averages -> first sample held, overrun=1;
//    clr_err pulse -> overrun=0; smp_ready=1 -> smp_valid=0 next cycle.
//  4 model holds adc_done=1 after trigger, TIMEOUT=255 -> timeout_err=1 after 255 clk in
//    WAIT_BUSY, FSM in IDLE; next tick still issues adc_trig.
//  5 conversion takes 150 clk, PERIOD=100 -> one adc_trig per conversion, no double pulse;
//    extra ticks dropped.
//  6 RST low during WAIT_DONE -> all outputs 0 asynchronously; after release, first
//    adc_trig only after a full PERIOD.

Source files
------------

// File: rtl/adc_sampler.sv
// adc_sampler: issues one ADC conversion per PERIOD clocks, box-car averages
// 2**AVG_LOG2 captures per channel and presents results on a valid/ready port.
module adc_sampler #(
    parameter int PERIOD   = 1000,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        en,
    output logic        adc_trig,
    input  logic        adc_done,
    input  logic [13:0] adc_a,
    input  logic [13:0] adc_b,
    output logic [13:0] smp_a,
    output logic [13:0] smp_b,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        clr_err
);

    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = 14 + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] N_LAST = NW'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_WBUSY = 3'd2;
    localparam logic [2:0] S_WDONE = 3'd3;
    localparam logic [2:0] S_ACC   = 3'd4;

    logic [2:0]           state;
    logic [PW-1:0]        pcnt;
    logic                 pending;
    logic [TW-1:0]        tcnt;
    logic signed [13:0]   cap_a, cap_b;
    logic signed [AW-1:0] acc_a, acc_b;
    logic [NW-1:0]        n;

    logic                 tick, in_wait, timed_out, avg_done;
    logic signed [AW-1:0] sum_a, sum_b;
    logic [13:0]          avg_a, avg_b;

    assign tick      = en && (pcnt == PW'(PERIOD - 1));
    assign in_wait   = (state == S_WBUSY) || (state == S_WDONE);
    assign timed_out = in_wait && (tcnt == TW'(TIMEOUT - 1));
    assign sum_a     = acc_a + AW'(cap_a);
    assign sum_b     = acc_b + AW'(cap_b);
    // arithmetic shift floors toward minus infinity, as the average requires
    assign avg_a     = 14'(sum_a >>> AVG_LOG2);
    assign avg_b     = 14'(sum_b >>> AVG_LOG2);
    assign avg_done  = (state == S_ACC) && (n == N_LAST);
    assign adc_trig  = (state == S_TRIG);

    // tick while a request is already pending is simply lost
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            pcnt    <= '0;
            pending <= 1'b0;
        end else begin
            pcnt <= (!en || tick) ? '0 : pcnt + 1'b1;
            if (state == S_IDLE && en && pending)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            tcnt  <= '0;
            cap_a <= '0;
            cap_b <= '0;
            acc_a <= '0;
            acc_b <= '0;
            n     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!en) begin
                        acc_a <= '0;
                        acc_b <= '0;
                        n     <= '0;
                    end
                    if (en && pending) state <= S_TRIG;
                end
                S_TRIG: begin
                    tcnt  <= '0;
                    state <= S_WBUSY;
                end
                S_WBUSY: begin
                    if (timed_out) state <= S_IDLE;
                    else begin
                        tcnt <= tcnt + 1'b1;
                        if (!adc_done) state <= S_WDONE;
                    end
                end
                S_WDONE: begin
                    if (timed_out) state <= S_IDLE;
                    else begin
                        tcnt <= tcnt + 1'b1;
                        if (adc_done) begin
                            cap_a <= adc_a;
                            cap_b <= adc_b;
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (n == N_LAST) begin
                        acc_a <= '0;
                        acc_b <= '0;
                        n     <= '0;
                    end else begin
                        acc_a <= sum_a;
                        acc_b <= sum_b;
                        n     <= n + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // a finished average is dropped, not queued, when the held sample is unread
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            smp_a       <= '0;
            smp_b       <= '0;
            smp_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (avg_done && (!smp_valid || smp_ready)) begin
                smp_a     <= avg_a;
                smp_b     <= avg_b;
                smp_valid <= 1'b1;
            end else if (!avg_done && smp_ready) begin
                smp_valid <= 1'b0;
            end
            overrun     <= (avg_done && smp_valid && !smp_ready) || (overrun && !clr_err);
            timeout_err <= timed_out || (timeout_err && !clr_err);
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: AVG_LOG2=0 and AVG_LOG2=2 instances share one ADC model
// and are compared each cycle against a queue/arithmetic reference.
module tb_adc_sampler;
    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, adc_done = 1'b1;
    logic smp_ready = 1'b1, clr_err = 1'b0;
    logic [13:0] adc_a = '0, adc_b = '0;
    logic trig[2], sv[2], ovr[2], tmo[2];
    logic [13:0] sa[2], sb[2];

    always #5 clk = ~clk;

    adc_sampler #(.PERIOD(PERIOD), .AVG_LOG2(0), .TIMEOUT(TIMEOUT)) dut0 (
        .CLK50MHZ(clk), .RST(rst_n), .en(en), .adc_trig(trig[0]), .adc_done(adc_done),
        .adc_a(adc_a), .adc_b(adc_b), .smp_a(sa[0]), .smp_b(sb[0]), .smp_valid(sv[0]),
        .smp_ready(smp_ready), .overrun(ovr[0]), .timeout_err(tmo[0]), .clr_err(clr_err));
    adc_sampler #(.PERIOD(PERIOD), .AVG_LOG2(2), .TIMEOUT(TIMEOUT)) dut2 (
        .CLK50MHZ(clk), .RST(rst_n), .en(en), .adc_trig(trig[1]), .adc_done(adc_done),
        .adc_a(adc_a), .adc_b(adc_b), .smp_a(sa[1]), .smp_b(sb[1]), .smp_valid(sv[1]),
        .smp_ready(smp_ready), .overrun(ovr[1]), .timeout_err(tmo[1]), .clr_err(clr_err));

    int vecs = 0, errs = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ADC model: busy from trig+1, result and done at trig+conv_len
    int ph = 0, k = 0, cur_len = 0, conv_len = 12, cyc = 0;
    bit hold = 0, conv_now = 0, prev_trig = 0;
    logic [27:0] dq[$];
    int trig_log[$];

    // reference model
    localparam int KL[2] = '{0, 2};
    bit st_v;
    logic [13:0] st_a, st_b;
    int sum_a[2], sum_b[2], cnt[2];
    logic exp_v[2], exp_o[2];
    logic [13:0] exp_a[2], exp_b[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v <= 0;
            for (int i = 0; i < 2; i++) begin
                sum_a[i] <= 0; sum_b[i] <= 0; cnt[i] <= 0;
                exp_v[i] <= 0; exp_o[i] <= 0; exp_a[i] <= '0; exp_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic logic signed [31:0] s_a = sum_a[i] + int'($signed(st_a));
                automatic logic signed [31:0] s_b = sum_b[i] + int'($signed(st_b));
                automatic logic signed [31:0] q_a = s_a >>> KL[i];
                automatic logic signed [31:0] q_b = s_b >>> KL[i];
                automatic bit done = st_v && (cnt[i] + 1 == (1 << KL[i]));
                automatic bit set_o = 0;
                if (st_v) begin
                    sum_a[i] <= done ? 0 : s_a;
                    sum_b[i] <= done ? 0 : s_b;
                    cnt[i]   <= done ? 0 : cnt[i] + 1;
                end else if (!en && ph == 0 && !conv_now) begin
                    sum_a[i] <= 0; sum_b[i] <= 0; cnt[i] <= 0;
                end
                if (done) begin
                    if (!exp_v[i] || smp_ready) begin
                        exp_v[i] <= 1; exp_a[i] <= q_a[13:0]; exp_b[i] <= q_b[13:0];
                    end else set_o = 1;
                end else if (smp_ready) exp_v[i] <= 0;
                exp_o[i] <= set_o || (exp_o[i] && !clr_err);
            end
            st_v <= conv_now;
            st_a <= adc_a;
            st_b <= adc_b;
        end
    end

    // per-cycle comparison, then the ADC model step
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("valid%0d", i), sv[i], exp_v[i]);
                if (exp_v[i]) begin
                    chk($sformatf("smp_a%0d", i), sa[i], exp_a[i]);
                    chk($sformatf("smp_b%0d", i), sb[i], exp_b[i]);
                end
                chk($sformatf("overrun%0d", i), ovr[i], exp_o[i]);
            end
            if (rst_n && trig[0]) begin
                trig_log.push_back(cyc);
                chk("trig_while_busy", ph, 0);
                chk("trig_width", prev_trig, 0);
            end
            prev_trig = trig[0];
            conv_now = 0;
            if (!rst_n) begin
                ph = 0; adc_done = 1;
            end else if (ph == 0) begin
                if (trig[0] && !hold) begin ph = 1; k = 0; cur_len = conv_len; end
            end else begin
                k++;
                if (k == 1) adc_done = 0;
                if (k == cur_len) begin
                    if (dq.size() > 0) {adc_a, adc_b} = dq.pop_front();
                    else begin adc_a = 14'($urandom); adc_b = 14'($urandom); end
                    adc_done = 1; conv_now = 1; ph = 0;
                end
            end
        end
    end

    task automatic wait_sv(input int idx, input int lim, input string name);
        int t = 0;
        while (!sv[idx] && t < lim) begin @(negedge clk); t++; end
        chk(name, sv[idx], 1);
    endtask

    task automatic wait_trig(input int lim, input string name);
        int t = 0;
        while (!trig[0] && t < lim) begin @(negedge clk); t++; end
        chk(name, trig[0], 1);
    endtask

    typedef struct {
        logic [3:0][13:0] a, b;
        logic [13:0] ea, eb;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int t, early, rmode;
        tbl[0] = '{a: {14'h3FF8, 14'h3FFC, 14'h0004, 14'h0004}, b: {4{14'h0005}},
                   ea: 14'h3FFF, eb: 14'h0005};
        tbl[1] = '{a: {4{14'h1FFF}}, b: {4{14'h2000}}, ea: 14'h1FFF, eb: 14'h2000};
        tbl[2] = '{a: {14'h0000, 14'h0001, 14'h0001, 14'h0001},
                   b: {14'h0000, 14'h0000, 14'h0000, 14'h3FFF}, ea: 14'h0000, eb: 14'h3FFF};
        tbl[3] = '{a: {14'h0000, 14'h0000, 14'h1FFF, 14'h2000}, b: {4{14'h0007}},
                   ea: 14'h3FFF, eb: 14'h0007};
        tbl[4] = '{a: {4{14'h3FFE}}, b: {14'h0000, 14'h0000, 14'h0000, 14'h0006},
                   ea: 14'h3FFE, eb: 14'h0001};
        tbl[5] = '{a: {4{14'h2000}}, b: {14'h1FFE, 14'h1FFF, 14'h1FFF, 14'h1FFF},
                   ea: 14'h2000, eb: 14'h1FFE};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_trig", trig[i], 0); chk("rst_valid", sv[i], 0);
            chk("rst_smp_a", sa[i], 0);  chk("rst_smp_b", sb[i], 0);
            chk("rst_ovr", ovr[i], 0);   chk("rst_tmo", tmo[i], 0);
        end
        rst_n = 1; en = 1;

        // averaging table, with trigger spacing checked on the side
        trig_log.delete();
        foreach (tbl[v]) begin
            for (int j = 0; j < 4; j++) dq.push_back({tbl[v].a[j], tbl[v].b[j]});
            wait_sv(1, 1000, "tbl_valid");
            chk($sformatf("tbl%0d_a", v), sa[1], tbl[v].ea);
            chk($sformatf("tbl%0d_b", v), sb[1], tbl[v].eb);
            @(negedge clk);
        end
        for (int i = 1; i < trig_log.size(); i++)
            chk("trig_period", trig_log[i] - trig_log[i-1], PERIOD);

        // conversions longer than PERIOD: retrigger 3 clocks after each completes
        conv_len = 150;
        trig_log.delete();
        t = 0;
        while (trig_log.size() < 4 && t < 1500) begin @(negedge clk); t++; end
        chk("slow_trig_count", trig_log.size(), 4);
        for (int i = 1; i < trig_log.size(); i++)
            chk("slow_trig_gap", trig_log[i] - trig_log[i-1], 153);
        conv_len = 12;
        repeat (2) begin wait_sv(1, 1500, "resync"); @(negedge clk); end

        // overrun: two averages while the consumer stalls
        smp_ready = 0;
        for (int j = 0; j < 4; j++) dq.push_back({14'd100, 14'h3FFD});
        for (int j = 0; j < 4; j++) dq.push_back({14'd200, 14'h0009});
        t = 0;
        while (!ovr[1] && t < 1500) begin @(negedge clk); t++; end
        chk("ovr_set", ovr[1], 1);
        chk("ovr_held_valid", sv[1], 1);
        chk("ovr_held_a", sa[1], 14'd100);
        chk("ovr_held_b", sb[1], 14'h3FFD);
        chk("ovr0_set", ovr[0], 1);
        clr_err = 1; @(negedge clk); clr_err = 0;
        chk("ovr_clr", ovr[1], 0);
        smp_ready = 1; @(negedge clk);
        chk("ready_drain", sv[1], 0);

        // handshake timeout: ADC never goes busy
        wait_sv(1, 1500, "pre_tmo"); @(negedge clk);
        hold = 1;
        wait_trig(300, "tmo_trig");
        repeat (255) @(negedge clk);
        chk("tmo_early", tmo[1], 0);
        @(negedge clk);
        chk("tmo_set0", tmo[0], 1);
        chk("tmo_set2", tmo[1], 1);
        hold = 0;
        @(negedge clk);
        chk("tmo_retrig", trig[0], 1);
        clr_err = 1; @(negedge clk); clr_err = 0;
        chk("tmo_clr", tmo[1], 0);

        // randomized traffic against the reference model
        rmode = 1;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (c % 64 == 0) rmode = $urandom_range(0, 3);
            smp_ready = (rmode != 0) && ($urandom_range(0, 3) != 0);
            clr_err = ($urandom_range(0, 99) == 0);
            conv_len = $urandom_range(2, 120);
        end
        smp_ready = 1; clr_err = 0; conv_len = 12;

        // en low: no further triggers
        wait_sv(1, 2000, "pre_en"); @(negedge clk);
        en = 0;
        repeat (5) @(negedge clk);
        early = 0;
        repeat (300) begin @(negedge clk); if (trig[0]) early++; end
        chk("en_off_trigs", early, 0);
        en = 1;

        // async reset mid-conversion
        conv_len = 40;
        wait_sv(1, 2000, "pre_rst");
        smp_ready = 0;
        wait_trig(300, "rst_trig_wait");
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_trig", trig[i], 0); chk("arst_valid", sv[i], 0);
            chk("arst_a", sa[i], 0);      chk("arst_b", sb[i], 0);
            chk("arst_ovr", ovr[i], 0);   chk("arst_tmo", tmo[i], 0);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1; smp_ready = 1;
        early = 0;
        for (int j = 1; j <= PERIOD + 1; j++) begin
            @(negedge clk);
            if (j <= PERIOD && trig[0]) early++;
        end
        chk("rst_no_early_trig", early, 0);
        chk("rst_first_trig", trig[0], 1);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
